// File: rtl/stream_ingress_adapter_if.sv
// Handshake bundle between the external input stream and the core's input port.
// The adapter uses the slave view; whatever drives the stream and the core's
// ready uses the master view.
interface stream_ingress_adapter_if #(
    parameter int W = 64
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         core_valid;
    logic         core_ready;
    logic [W-1:0] core_data;

    modport slave (
        input  s_valid, s_data, s_last, core_ready,
        output s_ready, core_valid, core_data
    );

    modport master (
        output s_valid, s_data, s_last, core_ready,
        input  s_ready, core_valid, core_data
    );
endinterface

// File: rtl/stream_ingress_adapter.sv
// Input framing adapter: forwards exactly the number of words the core expects
// for the latched mode/level (fixed part, optional length word, message words),
// checks the last marker, zero-pads short frames and drains long ones so the
// core never waits forever.
module stream_ingress_adapter #(
    parameter int W      = 64,
    parameter int MLEN_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [2:0]               sec_lvl,
    stream_ingress_adapter_if.slave  bus,
    output logic                     done,
    output logic                     err
);
    localparam int CW = 10;          // fixed-part counter, F <= 903
    localparam int MW = MLEN_W - 2;  // message-word counter, M <= 2^(MLEN_W-3)

    typedef enum logic [2:0] {
        S_IDLE, S_FIXED, S_MLEN, S_MSG, S_PAD, S_DRAIN, S_END
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, f_n, f_sel;
    logic            is_kg, cfg_ok;
    logic [MW-1:0]   msg_cnt, m_len, pad_rem, m_calc;
    logic [MLEN_W:0] m_sum;
    logic            xfer, fix_last, is_final;

    // Fixed-part word count and configuration check for the requested op.
    always_comb begin
        f_sel  = '0;
        cfg_ok = 1'b0;
        if (mode != 2'd3 && (sec_lvl == 3'd2 || sec_lvl == 3'd3 || sec_lvl == 3'd5)) begin
            cfg_ok = 1'b1;
            case (mode)
                2'd0: f_sel = CW'(4);
                2'd1: f_sel = (sec_lvl == 3'd2) ? CW'(320) : (sec_lvl == 3'd3) ? CW'(504) : CW'(612);
                default: f_sel = (sec_lvl == 3'd2) ? CW'(467) : (sec_lvl == 3'd3) ? CW'(658) : CW'(903);
            endcase
        end
    end

    // Message word count from the length word; one extra bit so L=all-ones cannot wrap.
    always_comb begin
        m_sum  = {1'b0, bus.s_data[MLEN_W-1:0]} + (MLEN_W+1)'(7);
        m_calc = MW'(m_sum >> 3);
    end

    // Transfer strobe and "this is the frame's final expected word" decode.
    always_comb begin
        xfer     = bus.s_valid && bus.core_ready;
        fix_last = (cnt == f_n - CW'(1));
        case (state)
            S_FIXED: is_final = is_kg && fix_last;
            S_MLEN:  is_final = (m_calc == '0);
            S_MSG:   is_final = (msg_cnt == m_len - MW'(1));
            default: is_final = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state: phase progression plus last-marker framing checks.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = cfg_ok ? S_FIXED : S_DRAIN;
            S_FIXED, S_MLEN, S_MSG: begin
                if (xfer) begin
                    if (bus.s_last)                      state_nxt = is_final ? S_END : S_PAD;
                    else if (is_final)                   state_nxt = S_DRAIN;
                    else if (state == S_FIXED && fix_last) state_nxt = S_MLEN;
                    else if (state == S_MLEN)            state_nxt = S_MSG;
                end
            end
            S_PAD:   if (bus.core_ready && pad_rem == MW'(1)) state_nxt = S_END;
            S_DRAIN: if (bus.s_valid && bus.s_last) state_nxt = S_END;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: pass-through while forwarding, zero words while padding, sink while draining.
    always_comb begin
        bus.s_ready    = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_data  = '0;
        done           = 1'b0;
        case (state)
            S_FIXED, S_MLEN, S_MSG: begin
                bus.s_ready    = bus.core_ready;
                bus.core_valid = bus.s_valid;
                bus.core_data  = bus.s_data;
            end
            S_PAD:   bus.core_valid = 1'b1;
            S_DRAIN: bus.s_ready    = 1'b1;
            S_END:   done           = 1'b1;
            default: ;
        endcase
    end

    // Word counters, latched op parameters and the remaining pad count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            msg_cnt <= '0;
            m_len   <= '0;
            pad_rem <= '0;
            f_n     <= '0;
            is_kg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cnt     <= '0;
                    msg_cnt <= '0;
                    f_n     <= f_sel;
                    is_kg   <= (mode == 2'd0);
                end
                S_FIXED: if (xfer) cnt <= cnt + CW'(1);
                S_MLEN:  if (xfer) m_len <= m_calc;
                S_MSG:   if (xfer) msg_cnt <= msg_cnt + MW'(1);
                S_PAD:   if (bus.core_ready) pad_rem <= pad_rem - MW'(1);
                default: ;
            endcase
            // Early last: pad what is still owed. In the fixed part of sign/verify
            // that includes a zero length word, so no message phase follows.
            if (state_nxt == S_PAD && state != S_PAD) begin
                case (state)
                    S_FIXED: pad_rem <= MW'(f_n - cnt - CW'(1)) + MW'(!is_kg);
                    S_MLEN:  pad_rem <= m_calc;
                    default: pad_rem <= m_len - msg_cnt - MW'(1);
                endcase
            end
        end
    end

    // Sticky framing error, cleared by an accepted start with a valid config.
    always_ff @(posedge clk) begin
        if (!rst)                                         err <= 1'b0;
        else if (state == S_IDLE && start)                err <= !cfg_ok;
        else if (state_nxt == S_PAD || state_nxt == S_DRAIN) err <= 1'b1;
    end
endmodule

// File: tb/tb_stream_ingress_adapter.sv
// Randomized bench for stream_ingress_adapter: frames are built from the word
// count rules, a reference model derives the words the core must see, the error
// flag and how many input words must be consumed.
module tb_stream_ingress_adapter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [2:0] sec_lvl = '0;
    logic       done, err;

    stream_ingress_adapter_if #(.W(64)) bus();

    stream_ingress_adapter #(.W(64), .MLEN_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .sec_lvl(sec_lvl),
        .bus(bus), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] fw[$];
    bit          fl[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit          exp_err;
    int          exp_used;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, expv);
        end
    endtask

    function automatic int f_words(input int md, input int lv);
        int li;
        li = (lv == 2) ? 0 : (lv == 3) ? 1 : (lv == 5) ? 2 : -1;
        if (li < 0 || md > 2) return 0;
        if (md == 0) return 4;
        if (md == 1) return (li == 0) ? 320 : (li == 1) ? 504 : 612;
        return (li == 0) ? 467 : (li == 1) ? 658 : 903;
    endfunction

    // Well-formed frame: F random words, then length word + message words for sign/verify.
    task automatic build(input int md, input int lv, input logic [31:0] len);
        int f;
        longint m;
        f = f_words(md, lv);
        fw.delete(); fl.delete();
        for (int i = 0; i < f; i++) begin fw.push_back({$urandom, $urandom}); fl.push_back(1'b0); end
        if (md != 0) begin
            fw.push_back({$urandom, len}); fl.push_back(1'b0);
            m = (longint'(len) + 7) >> 3;
            for (longint i = 0; i < m; i++) begin fw.push_back({$urandom, $urandom}); fl.push_back(1'b0); end
        end
        fl[fl.size()-1] = 1'b1;
    endtask

    task automatic build_n(input int n, input int last_at);
        fw.delete(); fl.delete();
        for (int i = 0; i < n; i++) begin fw.push_back(64'(i + 1)); fl.push_back(i == last_at); end
    endtask

    // Reference: walk the frame, extending the expected length once the length word is seen.
    task automatic model(input int md, input int lv);
        int f;
        longint n;
        f = f_words(md, lv);
        exp_q.delete(); exp_err = 1'b0; exp_used = 0;
        if (f == 0) begin
            exp_err = 1'b1;
            for (int i = 0; i < fw.size(); i++) if (fl[i]) begin exp_used = i + 1; break; end
            return;
        end
        n = (md == 0) ? f : f + 1;
        for (int i = 0; i < fw.size(); i++) begin
            exp_q.push_back(fw[i]);
            exp_used = i + 1;
            if (md != 0 && i == f) n = f + 1 + ((longint'(fw[i][31:0]) + 7) >> 3);
            if (fl[i]) begin
                if (i != n - 1) begin
                    exp_err = 1'b1;
                    for (longint j = i + 1; j < n; j++) exp_q.push_back(64'd0);
                end
                break;
            end
            if (i == n - 1) begin
                exp_err = 1'b1;
                for (int j = i + 1; j < fw.size(); j++) if (fl[j]) begin exp_used = j + 1; break; end
                break;
            end
        end
    endtask

    task automatic run_op(input int md, input int lv, input string tag);
        int   idx = 0, stray = 0, done_n = 0, post = 0, cyc = 0;
        logic err_seen = 1'b0;
        model(md, lv);
        got_q.delete();
        bus.s_valid = 1'b0;
        start = 1'b1; mode = 2'(md); sec_lvl = 3'(lv);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom); sec_lvl = 3'($urandom);
        while (cyc < 20000 && post < 4) begin
            bus.core_ready = 1'($urandom);
            start = (done_n == 0) && ($urandom_range(0, 15) == 0);
            if (idx < fw.size()) begin
                bus.s_valid = ($urandom_range(0, 3) != 0);
                bus.s_data  = fw[idx];
                bus.s_last  = fl[idx];
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = {$urandom, $urandom};
                bus.s_last  = 1'b0;
            end
            @(negedge clk);
            if (bus.core_valid && bus.core_ready) got_q.push_back(bus.core_data);
            if (bus.s_valid && bus.s_ready) begin
                if (idx < fw.size()) idx++;
                else stray++;
            end
            if (done) begin done_n++; err_seen = err; end
            if (done_n > 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; bus.s_valid = 1'b0;
        check({tag, ":finished"}, 64'(done_n > 0), 64'd1);
        check({tag, ":core_words"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            int b0 = bad;
            check({tag, ":word"}, got_q[i], exp_q[i]);
            if (bad != b0) break;
        end
        check({tag, ":consumed"}, 64'(idx), 64'(exp_used));
        check({tag, ":stray_accept"}, 64'(stray), 64'd0);
        check({tag, ":done_pulses"}, 64'(done_n), 64'd1);
        check({tag, ":err_at_done"}, 64'(err_seen), 64'(exp_err));
        check({tag, ":err_sticky"}, 64'(err), 64'(exp_err));
    endtask

    // Reset in the middle of a frame must return every output to zero at once.
    task automatic mid_reset(input int md, input int lv, input string tag);
        start = 1'b1; mode = 2'(md); sec_lvl = 3'(lv);
        @(posedge clk); #1;
        start = 1'b0;
        bus.core_ready = 1'b1; bus.s_valid = 1'b1; bus.s_last = 1'b0;
        repeat (2) begin
            bus.s_data = {$urandom, $urandom} | 64'd1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, ":s_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, ":core_valid"}, 64'(bus.core_valid), 64'd0);
        check({tag, ":core_data"}, bus.core_data, 64'd0);
        check({tag, ":done"}, 64'(done), 64'd0);
        check({tag, ":err"}, 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; bus.s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int md, lv, kind, k;
        bus.s_valid = 1'b1; bus.s_data = 64'hdead_beef_0000_0001; bus.s_last = 1'b0; bus.core_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset:s_ready", 64'(bus.s_ready), 64'd0);
        check("reset:core_valid", 64'(bus.core_valid), 64'd0);
        check("reset:core_data", bus.core_data, 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle:s_ready", 64'(bus.s_ready), 64'd0);
        check("idle:core_valid", 64'(bus.core_valid), 64'd0);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;

        build_n(4, 3);          run_op(0, 2, "keygen");
        build(1, 2, 32'd10);    run_op(1, 2, "sign2_L10");
        build(2, 3, 32'd0);     run_op(2, 3, "verify3_L0");
        build_n(2, 1);          run_op(0, 2, "early_last");
        build_n(6, 5);          run_op(0, 3, "missing_last");
        build_n(3, 2);          run_op(3, 2, "bad_mode");
        build_n(3, 2);          run_op(1, 4, "bad_level");
        // last on the length word while M=3 message words are still owed
        build(1, 2, 32'd20);
        while (fw.size() > 321) begin void'(fw.pop_back()); void'(fl.pop_back()); end
        fl[320] = 1'b1;         run_op(1, 2, "early_on_len");
        // last on the final fixed word of sign: only a zero length word is owed
        build(1, 5, 32'd9);
        while (fw.size() > 612) begin void'(fw.pop_back()); void'(fl.pop_back()); end
        fl[611] = 1'b1;         run_op(1, 5, "early_end_fixed");

        for (int r = 0; r < 8; r++) begin
            md = $urandom_range(0, 3);
            k  = $urandom_range(0, 3);
            lv = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 5 : (($urandom_range(0, 1) == 0) ? 1 : 4);
            if (f_words(md, lv) == 0) begin
                build_n(3, 2);
                for (int i = 0; i < 3; i++) fw[i] = {$urandom, $urandom};
            end else begin
                build(md, lv, {$urandom_range(0, 15) == 0 ? 32'd0 : 32'($urandom_range(1, 40))});
                kind = $urandom_range(0, 2);
                if (kind == 1) begin
                    k = $urandom_range(0, fw.size() - 2);
                    while (fw.size() > k + 1) begin void'(fw.pop_back()); void'(fl.pop_back()); end
                    fl[k] = 1'b1;
                end else if (kind == 2) begin
                    fl[fl.size()-1] = 1'b0;
                    k = $urandom_range(1, 3);
                    for (int i = 0; i < k; i++) begin fw.push_back({$urandom, $urandom}); fl.push_back(i == k - 1); end
                end
            end
            run_op(md, lv, $sformatf("rand%0d_m%0d_l%0d", r, md, lv));
        end

        build_n(3, 2);          run_op(3, 5, "bad_before_reset");
        mid_reset(3, 2, "rst_in_drain");
        mid_reset(0, 2, "rst_in_fixed");
        build_n(4, 3);          run_op(0, 5, "keygen_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_ingress_adapter.md
Name: stream_ingress_adapter

Overview:
- Input-side framing adapter between the external AXI-Stream-style input (valid/ready/data/last) and the core's valid_i/ready_i/data_i port.
- Per operation, computes the word count the core expects from mode, sec_lvl and the in-band message-length word. Forwards exactly that many words, enforces the last marker and flags framing errors.
- On an error the core never hangs: short frames are zero-padded and long frames are drained.

Parameters:
- W, 64, stream data width in bits; fixed at 64, byte-length math assumes 8 bytes per word.
- MLEN_W, 32, width of the byte-length field taken from data[MLEN_W-1:0] of the length word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle strobe starting an operation; sampled only in IDLE
- mode  in  2  0=keygen, 1=sign, 2=verify, 3=invalid; latched at start
- sec_lvl  in  3  2, 3 or 5; other values are invalid; latched at start
- s_valid  in  1  external input word valid
- s_ready  out  1  external input ready
- s_data  in  W  external input word
- s_last  in  1  final word of the external frame
- core_valid  out  1  word valid toward the core
- core_ready  in  1  core accepts the word
- core_data  out  W  word toward the core
- done  out  1  one-cycle pulse when the operation's input phase completes
- err  out  1  sticky framing error; cleared at the next accepted start

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, all counters 0. s_ready=0, core_valid=0, core_data=0, done=0, err=0. Reset mid-operation aborts immediately; no pad or drain follows.
- Fixed-part word counts F(mode, sec_lvl):
  - keygen: 4 for every level.
  - sign: 320 / 504 / 612 for levels 2 / 3 / 5.
  - verify: 467 / 658 / 903 for levels 2 / 3 / 5.
- Frame layout:
  - keygen: exactly F words, no length word.
  - sign and verify: F words, then 1 length word L = s_data[MLEN_W-1:0] (bytes), then M = (L+7)>>3 message words.
- States:
  - IDLE: s_ready=0, core_valid=0. On start with a valid mode/level: clear err, word counter cnt=0, go FIXED. On start with an invalid mode/level: set err, go DRAIN.
  - FIXED, MLEN, MSG (forwarding states): combinational pass-through with core_valid=s_valid, s_ready=core_ready, core_data=s_data. A word transfers when s_valid && core_ready.
    - FIXED: after the F-th transfer, keygen goes to END; sign/verify go to MLEN.
    - MLEN: the length word is forwarded too. Latch M. M==0 goes to END; otherwise go to MSG.
    - MSG: count M transfers, then go to END.
  - last checking in the forwarding states:
    - The frame's final expected word must carry s_last=1; that transfer goes to END.
    - s_last=1 on an earlier word: the word is forwarded, err is set, go PAD. If it arrives in FIXED for sign/verify, PAD sends the remaining fixed words plus a zero length word (M=0).
    - The final expected word without s_last: it is forwarded, err is set, go DRAIN.
  - PAD: s_ready=0, core_valid=1, core_data=0. Hold until core_ready; count the remaining expected words, then go END.
  - DRAIN: s_ready=1, core_valid=0. Discard words until a transfer with s_last=1, then go END.
  - END: done=1 for one cycle, s_ready=0, then go IDLE.
- Counter widths: cnt is at least 10 bits for F; the message counter is MLEN_W-2 bits. M computation must not overflow at L=2^MLEN_W-1; compute it at MLEN_W+1 bits.
- start outside IDLE is ignored. s_valid without a prior start is never accepted (s_ready=0).
- Latency: zero-cycle combinational forwarding. One cycle in END. The next start is accepted in the cycle after END.

Test Plan:
- Keygen: start, mode=0, sec_lvl=2; 4 words 0x1..0x4 with last on word 4 -> core sees 4 identical words, done pulses once, err=0.
- Sign, sec_lvl=2, L=10: 320 words + length word + 2 message words, last on word 323 -> 323 words forwarded, done, err=0. Random core_ready stalls (~50%) -> no word lost or duplicated; s_ready tracks core_ready.
- Verify, sec_lvl=3, L=0: 658 words + length word, last on the length word -> 659 words forwarded, no MSG phase, done, err=0.
- Early last: keygen with last on word 2 -> core gets 0x1, 0x2 then 2 zero words; err=1, done.
- Missing last: keygen with 6 words, last on word 6 -> core gets 4 words; words 5-6 consumed and not forwarded; err=1; done after word 6.
- Invalid mode=3: start with a 3-word frame -> frame drained, nothing forwarded, err=1. Separately, rst=0 mid-frame -> IDLE next cycle with all outputs 0.
